// File: rtl/i_line_prefetcher.sv
// Sequential instruction-line prefetcher: on a stream-buffer miss it fetches
// PREFETCH_DEPTH consecutive lines over AXI read bursts and offers each assembled line.
module i_line_prefetcher #(
  parameter int         ADDR_WIDTH         = 32,
  parameter int         DATA_WIDTH         = 32,
  parameter int         BLOCK_OFFSET_WIDTH = 2,
  parameter int         PREFETCH_DEPTH     = 4,
  parameter logic [3:0] AXI_ID             = 4'd2
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       miss_valid,
  input  logic [ADDR_WIDTH-1:0]                      miss_addr,
  input  logic                                       flush,
  output logic                                       ar_valid,
  input  logic                                       ar_ready,
  output logic [ADDR_WIDTH-1:0]                      ar_addr,
  output logic [7:0]                                 ar_len,
  output logic [3:0]                                 ar_id,
  input  logic                                       r_valid,
  output logic                                       r_ready,
  input  logic [DATA_WIDTH-1:0]                      r_data,
  input  logic [3:0]                                 r_id,
  input  logic                                       r_last,
  output logic                                       line_valid,
  input  logic                                       line_ready,
  output logic [ADDR_WIDTH-1:0]                      line_addr,
  output logic [DATA_WIDTH*(1<<BLOCK_OFFSET_WIDTH)-1:0] line_data,
  output logic                                       busy
);

  localparam int LINE_SIZE  = 1 << BLOCK_OFFSET_WIDTH;
  localparam int LINE_SHIFT = BLOCK_OFFSET_WIDTH + 2;
  localparam int LINE_W     = DATA_WIDTH * LINE_SIZE;

  localparam logic [ADDR_WIDTH-1:0] LINE_BYTES = ADDR_WIDTH'(1) << LINE_SHIFT;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK  = ~(LINE_BYTES - ADDR_WIDTH'(1));
  localparam logic [3:0]            DEPTH      = 4'(PREFETCH_DEPTH);
  localparam logic [BLOCK_OFFSET_WIDTH-1:0] LAST_BEAT = BLOCK_OFFSET_WIDTH'(LINE_SIZE - 1);
  localparam logic [BLOCK_OFFSET_WIDTH-1:0] BEAT_ONE  = BLOCK_OFFSET_WIDTH'(1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_BEAT  = 3'd2;
  localparam logic [2:0] ST_PUSH  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  logic [2:0]                    state_r,      state_nxt_s;
  logic [ADDR_WIDTH-1:0]         cur_addr_r,   cur_addr_nxt_s;
  logic [3:0]                    remaining_r,  remaining_nxt_s;
  logic [BLOCK_OFFSET_WIDTH-1:0] beat_cnt_r,   beat_cnt_nxt_s;
  logic [LINE_W-1:0]             line_r,       line_nxt_s;
  logic                          pend_valid_r, pend_valid_nxt_s;
  logic [ADDR_WIDTH-1:0]         pend_addr_r,  pend_addr_nxt_s;

  logic [ADDR_WIDTH-1:0] miss_line_s;
  logic [ADDR_WIDTH-1:0] span_s;
  logic [ADDR_WIDTH-1:0] offset_s;
  logic                  in_range_s;
  logic                  miss_new_s;
  logic                  r_ready_s;
  logic                  beat_fire_s;
  logic                  beat_end_s;
  logic                  restart_s;
  logic [ADDR_WIDTH-1:0] restart_addr_s;

  // Miss classification, beat handshake and restart selection
  always_comb begin
    miss_line_s = miss_addr & LINE_MASK;
    span_s      = ADDR_WIDTH'(remaining_r) << LINE_SHIFT;
    // modular distance keeps the window correct across address wrap
    offset_s    = miss_line_s - cur_addr_r;
    in_range_s  = (offset_s < span_s);
    miss_new_s  = miss_valid && (flush || (state_r == ST_DRAIN) || !in_range_s);
    r_ready_s   = ((state_r == ST_BEAT) || (state_r == ST_DRAIN)) && (r_id == AXI_ID);
    beat_fire_s = r_valid && r_ready_s;
    beat_end_s  = r_last || (beat_cnt_r == LAST_BEAT);
    // a flush discards older pending work; a miss in the same cycle survives it
    restart_s      = miss_new_s || (pend_valid_r && !flush);
    restart_addr_s = miss_new_s ? miss_line_s : pend_addr_r;
  end

  // Next-state logic for the fetch sequencer
  always_comb begin
    state_nxt_s      = state_r;
    cur_addr_nxt_s   = cur_addr_r;
    remaining_nxt_s  = remaining_r;
    beat_cnt_nxt_s   = beat_cnt_r;
    line_nxt_s       = line_r;
    pend_valid_nxt_s = pend_valid_r;
    pend_addr_nxt_s  = pend_addr_r;

    if (state_r != ST_IDLE) begin
      if (flush) begin
        pend_valid_nxt_s = miss_new_s;
        pend_addr_nxt_s  = miss_line_s;
      end else if (miss_new_s) begin
        pend_valid_nxt_s = 1'b1;
        pend_addr_nxt_s  = miss_line_s;
      end else begin
        pend_valid_nxt_s = pend_valid_r;
      end
    end else begin
      pend_valid_nxt_s = 1'b0;
    end

    case (state_r)
      ST_IDLE: begin
        if (miss_valid) begin
          cur_addr_nxt_s  = miss_line_s;
          remaining_nxt_s = DEPTH;
          state_nxt_s     = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (ar_ready) begin
          // the address was accepted, so its beats must be collected even under flush
          beat_cnt_nxt_s = '0;
          state_nxt_s    = flush ? ST_DRAIN : ST_BEAT;
        end else if (flush) begin
          if (restart_s) begin
            cur_addr_nxt_s   = restart_addr_s;
            remaining_nxt_s  = DEPTH;
            pend_valid_nxt_s = 1'b0;
            state_nxt_s      = ST_REQ;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_BEAT: begin
        if (beat_fire_s) begin
          line_nxt_s[beat_cnt_r*DATA_WIDTH +: DATA_WIDTH] = r_data;
          beat_cnt_nxt_s = beat_cnt_r + BEAT_ONE;
        end else begin
          beat_cnt_nxt_s = beat_cnt_r;
        end
        if (beat_fire_s && beat_end_s) begin
          if (!flush) begin
            state_nxt_s = ST_PUSH;
          end else if (restart_s) begin
            cur_addr_nxt_s   = restart_addr_s;
            remaining_nxt_s  = DEPTH;
            pend_valid_nxt_s = 1'b0;
            state_nxt_s      = ST_REQ;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else if (flush) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_BEAT;
        end
      end
      ST_DRAIN: begin
        if (beat_fire_s) begin
          beat_cnt_nxt_s = beat_cnt_r + BEAT_ONE;
        end else begin
          beat_cnt_nxt_s = beat_cnt_r;
        end
        if (beat_fire_s && beat_end_s) begin
          if (restart_s) begin
            cur_addr_nxt_s   = restart_addr_s;
            remaining_nxt_s  = DEPTH;
            pend_valid_nxt_s = 1'b0;
            state_nxt_s      = ST_REQ;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_PUSH: begin
        if (flush || line_ready) begin
          if (restart_s) begin
            cur_addr_nxt_s   = restart_addr_s;
            remaining_nxt_s  = DEPTH;
            pend_valid_nxt_s = 1'b0;
            state_nxt_s      = ST_REQ;
          end else if (flush || (remaining_r == 4'd1)) begin
            remaining_nxt_s = 4'd0;
            state_nxt_s     = ST_IDLE;
          end else begin
            remaining_nxt_s = remaining_r - 4'd1;
            cur_addr_nxt_s  = cur_addr_r + LINE_BYTES;
            state_nxt_s     = ST_REQ;
          end
        end else begin
          state_nxt_s = ST_PUSH;
        end
      end
      default: begin
        state_nxt_s      = ST_IDLE;
        pend_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cur_addr_r   <= '0;
      remaining_r  <= 4'd0;
      beat_cnt_r   <= '0;
      line_r       <= '0;
      pend_valid_r <= 1'b0;
      pend_addr_r  <= '0;
    end else begin
      state_r      <= state_nxt_s;
      cur_addr_r   <= cur_addr_nxt_s;
      remaining_r  <= remaining_nxt_s;
      beat_cnt_r   <= beat_cnt_nxt_s;
      line_r       <= line_nxt_s;
      pend_valid_r <= pend_valid_nxt_s;
      pend_addr_r  <= pend_addr_nxt_s;
    end
  end

  assign ar_valid   = (state_r == ST_REQ);
  assign ar_addr    = cur_addr_r;
  assign ar_len     = 8'(LINE_SIZE - 1);
  assign ar_id      = AXI_ID;
  assign r_ready    = r_ready_s;
  assign line_valid = (state_r == ST_PUSH);
  assign line_addr  = cur_addr_r;
  assign line_data  = line_r;
  assign busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_i_line_prefetcher.sv
// Scoreboard bench for i_line_prefetcher: expected AR addresses and lines are queued
// as stimulus is issued and compared when the DUT handshakes them.
module tb_i_line_prefetcher;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         miss_valid;
  logic [31:0]  miss_addr;
  logic         flush;
  logic         ar_valid;
  logic         ar_ready;
  logic [31:0]  ar_addr;
  logic [7:0]   ar_len;
  logic [3:0]   ar_id;
  logic         r_valid;
  logic         r_ready;
  logic [31:0]  r_data;
  logic [3:0]   r_id;
  logic         r_last;
  logic         line_valid;
  logic         line_ready;
  logic [31:0]  line_addr;
  logic [127:0] line_data;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;
  int r_beats  = 0;
  int ar_hs    = 0;
  int ar_exp_total = 0;
  int bad_id_cycles = 0;
  int beat_idx = 0;
  logic r_fire_seen = 1'b0;

  logic [31:0]  exp_ar_q[$];
  logic [31:0]  exp_la_q[$];
  logic [127:0] exp_ld_q[$];
  logic [31:0]  burst_q[$];

  i_line_prefetcher dut (
    .clk(clk), .rst_n(rst_n), .miss_valid(miss_valid), .miss_addr(miss_addr), .flush(flush),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len), .ar_id(ar_id),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_id(r_id), .r_last(r_last),
    .line_valid(line_valid), .line_ready(line_ready), .line_addr(line_addr),
    .line_data(line_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] beat_data(input logic [31:0] a, input int b);
    if (a == 32'h0000_1230) return 32'h0000_000A + 32'(b);
    return {a[27:0], 4'(b)};
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] a);
    return {beat_data(a, 3), beat_data(a, 2), beat_data(a, 1), beat_data(a, 0)};
  endfunction

  task automatic expect_ar(input logic [31:0] a);
    exp_ar_q.push_back(a);
    ar_exp_total++;
  endtask

  task automatic expect_seq(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] la;
      la = a + 32'(i * 16);
      expect_ar(la);
      exp_la_q.push_back(la);
      exp_ld_q.push_back(line_of(la));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_miss(input logic [31:0] a);
    miss_addr  = a;
    miss_valid = 1'b1;
    step();
    miss_valid = 1'b0;
  endtask

  task automatic wait_beats(input int target);
    for (int i = 0; i < 200; i++) begin
      if (r_beats >= target) break;
      step();
    end
    check("beat_wait", 128'(r_beats >= target), 128'(1));
  endtask

  task automatic wait_idle(input string tag);
    step();
    for (int i = 0; i < 500; i++) begin
      if (!busy) break;
      step();
    end
    check({tag, "_idle"}, 128'(busy), 128'(0));
    check({tag, "_slave_drained"}, 128'(burst_q.size()), 128'(0));
  endtask

  // Monitor: scoreboard compares on AR and line handshakes, tracks consumed beats
  always @(negedge clk) begin
    r_fire_seen = r_valid && r_ready;
    if (r_fire_seen) r_beats++;
    if (rst_n && r_valid && (r_id != 4'd2)) check("rready_foreign_id", 128'(r_ready), 128'(0));
    if (rst_n && ar_valid && ar_ready) begin
      logic [31:0] ea;
      ea = (exp_ar_q.size() > 0) ? exp_ar_q.pop_front() : 32'hDEAD_BEEF;
      check("ar_addr", 128'(ar_addr), 128'(ea));
      burst_q.push_back(ar_addr);
      ar_hs++;
    end
    if (rst_n && line_valid && line_ready) begin
      logic [31:0]  ea;
      logic [127:0] ed;
      ea = (exp_la_q.size() > 0) ? exp_la_q.pop_front() : 32'hDEAD_BEEF;
      ed = (exp_ld_q.size() > 0) ? exp_ld_q.pop_front() : {4{32'hDEAD_BEEF}};
      check("line_addr", 128'(line_addr), 128'(ea));
      check("line_data", line_data, ed);
    end
  end

  // AXI read-data slave: four beats per accepted address, in order
  initial begin
    r_valid = 1'b0; r_data = 32'h0; r_id = 4'd2; r_last = 1'b0;
    forever begin
      step();
      if (r_fire_seen && burst_q.size() > 0) begin
        beat_idx++;
        if (beat_idx == 4) begin
          beat_idx = 0;
          void'(burst_q.pop_front());
        end
      end
      if (burst_q.size() > 0) begin
        r_valid = 1'b1;
        r_data  = beat_data(burst_q[0], beat_idx);
        r_last  = (beat_idx == 3);
        if (bad_id_cycles > 0) begin
          r_id = 4'd5;
          bad_id_cycles--;
        end else begin
          r_id = 4'd2;
        end
      end else begin
        r_valid = 1'b0;
        r_last  = 1'b0;
        r_id    = 4'd2;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n = 1'b0; miss_valid = 1'b0; miss_addr = 32'h0; flush = 1'b0;
    ar_ready = 1'b1; line_ready = 1'b1;
    repeat (3) step();
    check("rst_ar_valid",   128'(ar_valid),   128'(0));
    check("rst_r_ready",    128'(r_ready),    128'(0));
    check("rst_line_valid", 128'(line_valid), 128'(0));
    check("rst_busy",       128'(busy),       128'(0));
    check("rst_ar_addr",    128'(ar_addr),    128'(0));
    check("rst_line_addr",  128'(line_addr),  128'(0));
    check("rst_line_data",  line_data,        128'(0));
    check("rst_ar_len",     128'(ar_len),     128'(3));
    check("rst_ar_id",      128'(ar_id),      128'(2));
    rst_n = 1'b1;
    step();

    // basic miss: four sequential lines from the aligned miss address
    expect_seq(32'h0000_1230, 4);
    pulse_miss(32'h0000_1234);
    check("t1_busy", 128'(busy), 128'(1));
    check("t1_ar_len", 128'(ar_len), 128'(3));
    wait_idle("t1");

    // address channel stall: request held for five cycles
    ar_ready = 1'b0;
    expect_seq(32'h0000_2000, 4);
    pulse_miss(32'h0000_2008);
    for (int i = 0; i < 5; i++) begin
      check("t2_ar_valid_hold", 128'(ar_valid), 128'(1));
      check("t2_ar_addr_hold",  128'(ar_addr),  128'(32'h0000_2000));
      step();
    end
    ar_ready = 1'b1;
    wait_idle("t2");

    // line channel stall
    line_ready = 1'b0;
    expect_seq(32'h0000_3000, 4);
    pulse_miss(32'h0000_300C);
    for (int i = 0; i < 100; i++) begin
      if (line_valid) break;
      step();
    end
    for (int i = 0; i < 3; i++) begin
      check("t3_line_valid_hold", 128'(line_valid), 128'(1));
      check("t3_line_data_hold",  line_data, line_of(32'h0000_3000));
      check("t3_no_ar",           128'(ar_valid), 128'(0));
      step();
    end
    line_ready = 1'b1;
    wait_idle("t3");

    // flush after two beats: remaining beats drained, no line
    base = r_beats;
    expect_ar(32'h0000_4000);
    pulse_miss(32'h0000_4000);
    wait_beats(base + 2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_idle("t4");
    check("t4_beats_drained", 128'(r_beats - base), 128'(4));

    // wrap-around sequence
    expect_seq(32'hFFFF_FFF0, 4);
    pulse_miss(32'hFFFF_FFF4);
    wait_idle("t5");

    // out-of-window miss during BEAT restarts after the current line
    base = r_beats;
    expect_seq(32'h0000_1230, 1);
    expect_seq(32'h0000_8000, 4);
    pulse_miss(32'h0000_1230);
    wait_beats(base + 1);
    pulse_miss(32'h0000_8004);
    wait_idle("t6");

    // in-window miss is ignored
    base = r_beats;
    expect_seq(32'h0000_6000, 4);
    pulse_miss(32'h0000_6000);
    wait_beats(base + 1);
    pulse_miss(32'h0000_6024);
    wait_idle("t7");

    // flush while the request is still unaccepted
    ar_ready = 1'b0;
    pulse_miss(32'h0000_5000);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t8_flush_req_idle", 128'(busy), 128'(0));
    check("t8_flush_req_no_ar", 128'(ar_valid), 128'(0));
    ar_ready = 1'b1;

    // beats with a foreign ID are left untouched
    bad_id_cycles = 3;
    expect_seq(32'h0000_7000, 4);
    pulse_miss(32'h0000_7000);
    wait_idle("t9");

    check("end_ar_count",   128'(ar_hs), 128'(ar_exp_total));
    check("end_ar_q_empty", 128'(exp_ar_q.size()), 128'(0));
    check("end_line_q_empty", 128'(exp_la_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i_line_prefetcher.md
I_LINE_PREFETCHER -- requirements
Module: i_line_prefetcher

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI beat / instruction width.
REQ-003 SHALL have parameter BLOCK_OFFSET_WIDTH, default 2, log2 words per line (LINE_SIZE = 4 words, LINE_BYTES = 16).
REQ-004 SHALL have parameter PREFETCH_DEPTH, default 4, number of sequential lines fetched per miss, range 1..15.
REQ-005 SHALL have parameter AXI_ID, default 4'd2, read ID for all issued requests.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port miss_valid, input, 1 bit: the stream buffer reports a miss this cycle.
REQ-009 SHALL have port miss_addr, input, ADDR_WIDTH bits: missing PC.
REQ-010 SHALL have port flush, input, 1 bit: cancel all outstanding prefetch work.
REQ-011 SHALL have port ar_valid, output, 1 bit: AXI read-address valid.
REQ-012 SHALL have port ar_ready, input, 1 bit: AXI read-address ready.
REQ-013 SHALL have port ar_addr, output, ADDR_WIDTH bits: line-aligned burst address.
REQ-014 SHALL have port ar_len, output, 8 bits: burst length minus one.
REQ-015 SHALL have port ar_id, output, 4 bits: equals AXI_ID.
REQ-016 SHALL have port r_valid, input, 1 bit: AXI read-data valid.
REQ-017 SHALL have port r_ready, output, 1 bit: AXI read-data ready.
REQ-018 SHALL have port r_data, input, DATA_WIDTH bits: beat data.
REQ-019 SHALL have port r_id, input, 4 bits: beat ID.
REQ-020 SHALL have port r_last, input, 1 bit: final beat of burst.
REQ-021 SHALL have port line_valid, output, 1 bit: assembled line offered to the stream buffer.
REQ-022 SHALL have port line_ready, input, 1 bit: stream buffer accepts the line.
REQ-023 SHALL have port line_addr, output, ADDR_WIDTH bits: line-aligned address of the offered line.
REQ-024 SHALL have port line_data, output, DATA_WIDTH*LINE_SIZE bits: word 0 in the least significant bits.
REQ-025 SHALL have port busy, output, 1 bit: FSM not in IDLE.

Function
REQ-026 SHALL implement FSM states IDLE, REQ, BEAT, PUSH, DRAIN.
REQ-027 SHALL, in IDLE with miss_valid=1, latch cur_addr = miss_addr with low BLOCK_OFFSET_WIDTH+2 bits cleared and remaining = PREFETCH_DEPTH, then go to REQ (ar_valid high the next cycle).
REQ-028 SHALL, in REQ, drive ar_valid=1, ar_addr=cur_addr, ar_len=LINE_SIZE-1 and hold all three stable until ar_valid&&ar_ready, then go to BEAT with beat_cnt=0.
REQ-029 SHALL drive r_ready = (state is BEAT or DRAIN) && r_id==AXI_ID; beats carrying another ID are never consumed.
REQ-030 SHALL, in BEAT, on each accepted beat write r_data into word[beat_cnt] and increment beat_cnt; the beat with r_last=1, or beat_cnt==LINE_SIZE-1, moves the FSM to PUSH.
REQ-031 SHALL, in PUSH, hold line_valid=1 with stable line_addr=cur_addr and line_data until line_ready=1; then decrement remaining; go to IDLE when it reaches 0, else add LINE_BYTES to cur_addr (mod 2^ADDR_WIDTH) and go to REQ.
REQ-032 SHALL latch a miss_valid arriving outside IDLE as pending_addr; once the current line is pushed (or dropped), remaining work is discarded and a new sequence starts at pending_addr via REQ.
REQ-033 SHALL ignore miss_valid outside IDLE when its line address lies within [cur_addr, cur_addr+remaining*LINE_BYTES).
REQ-034 SHALL handle flush as follows: in REQ, go to IDLE immediately; in BEAT, go to DRAIN, consuming and discarding beats through r_last, then go to IDLE; in PUSH, drop the line and go to IDLE; any pending miss is cleared.
REQ-035 SHALL treat flush and miss_valid in the same cycle as a miss that becomes pending after the flush action (restart instead of IDLE).
REQ-036 SHALL guarantee that a handshaked address request is always followed by consumption of all of its beats; no burst is abandoned.

Reset
REQ-037 SHALL, while rst_n=0, force state=IDLE, ar_valid=0, r_ready=0, line_valid=0, busy=0, ar_addr=0, line_addr=0, line_data=0, pending cleared; a reset mid-burst drops the burst.
REQ-038 SHALL drive ar_len=LINE_SIZE-1 and ar_id=AXI_ID constantly, including during reset.

Verification
REQ-039 SHALL cover: miss_addr=0x0000_1234 with ar_ready=1 and beats 0xA,0xB,0xC,0xD (last on 0xD) -> ar_addr 0x1230, line_addr 0x1230, line_data {0xD,0xC,0xB,0xA}, then requests at 0x1240, 0x1250, 0x1260, then IDLE.
REQ-040 SHALL cover: ar_ready low for 5 cycles -> ar_valid and ar_addr held stable for 5 cycles, single handshake.
REQ-041 SHALL cover: line_ready low for 3 cycles in PUSH -> line_valid and line_data stable, no new ar_valid.
REQ-042 SHALL cover: flush after beat 2 -> beats 3-4 consumed, no line_valid, IDLE after r_last.
REQ-043 SHALL cover: miss 0xFFFF_FFF0 with PREFETCH_DEPTH=4 -> line addresses 0xFFFF_FFF0, 0x0, 0x10, 0x20.
REQ-044 SHALL cover: new miss 0x8000 during BEAT of 0x1230 -> line 0x1230 still pushed, next ar_addr 0x8000.
